// File: rtl/lpc_ringbuf_ctrl.sv
// Slot allocator for the LPC capture ring: one write in flight, FIFO-ordered readout of committed slots.
// write_start is registered (1 cycle after frame_valid); frames with no free slot or while a write is in flight are dropped and counted.
module lpc_ringbuf_ctrl #(
  parameter int SLOT_BITS = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 frame_valid,
  output logic                 write_start,
  output logic [SLOT_BITS-1:0] write_slot,
  input  logic                 write_done,
  output logic                 rd_valid,
  output logic [SLOT_BITS-1:0] rd_slot,
  input  logic                 rd_done,
  output logic [SLOT_BITS:0]   count,
  output logic                 full,
  output logic [7:0]           drop_count,
  output logic                 overflow,
  output logic                 write_timeout
);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wstate_t;

  localparam logic [SLOT_BITS:0]   DEPTH     = {1'b1, {SLOT_BITS{1'b0}}};
  localparam logic [SLOT_BITS:0]   CNT_ONE   = {{SLOT_BITS{1'b0}}, 1'b1};
  localparam logic [SLOT_BITS-1:0] PTR_ONE   = {{(SLOT_BITS-1){1'b0}}, 1'b1};
  localparam logic [7:0]           TMO_LIMIT = 8'(TIMEOUT);

  wstate_t              state;
  wstate_t              state_nxt;
  logic [SLOT_BITS-1:0] wr_ptr;
  logic [SLOT_BITS-1:0] rd_ptr;
  logic [7:0]           tmo_cnt;
  logic                 accept;
  logic                 commit;
  logic                 drop;
  logic                 tmo_hit;
  logic                 pop;

  assign full     = (count == DEPTH);
  assign rd_valid = (count != '0);
  assign rd_slot  = rd_ptr;
  assign pop      = rd_done && rd_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= W_IDLE;
    end else if (flush) begin
      state <= W_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      W_IDLE: begin
        if (frame_valid) begin
          if (full) begin
            drop = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = W_BUSY;
          end
        end
      end
      W_BUSY: begin
        drop = frame_valid;
        // write_done wins over an expiring timeout in the same cycle
        if (write_done) begin
          commit    = 1'b1;
          state_nxt = W_IDLE;
        end else if (tmo_cnt == TMO_LIMIT) begin
          tmo_hit   = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_start   <= 1'b0;
      write_slot    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tmo_cnt       <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
      write_timeout <= 1'b0;
    end else if (flush) begin
      write_start   <= 1'b0;
      write_slot    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tmo_cnt       <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
      write_timeout <= 1'b0;
    end else begin
      write_start <= accept;
      if (accept) begin
        write_slot <= wr_ptr;
        tmo_cnt    <= '0;
      end else if ((state == W_BUSY) && !commit && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (commit) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      // simultaneous commit and pop leaves count unchanged
      if (commit && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !commit) begin
        count <= count - CNT_ONE;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
      if (tmo_hit) begin
        write_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpc_ringbuf_ctrl.sv
// Directed bench for lpc_ringbuf_ctrl: queue-based reference model compared every cycle, plus literal spot checks.
module tb_lpc_ringbuf_ctrl;

  localparam int SB    = 5;
  localparam int TMO   = 15;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          frame_valid = 1'b0;
  logic          write_done = 1'b0;
  logic          rd_done = 1'b0;
  logic          write_start;
  logic [SB-1:0] write_slot;
  logic          rd_valid;
  logic [SB-1:0] rd_slot;
  logic [SB:0]   count;
  logic          full;
  logic [7:0]    drop_count;
  logic          overflow;
  logic          write_timeout;

  int n_pass  = 0;
  int n_total = 0;

  lpc_ringbuf_ctrl #(.SLOT_BITS(SB), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .flush(flush), .frame_valid(frame_valid),
    .write_start(write_start), .write_slot(write_slot), .write_done(write_done),
    .rd_valid(rd_valid), .rd_slot(rd_slot), .rd_done(rd_done), .count(count),
    .full(full), .drop_count(drop_count), .overflow(overflow), .write_timeout(write_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: committed slots kept as a queue, in commit order.
  int q[$];
  int nxt, m_slot, m_drops, edge_no, deadline;
  bit busy, m_start, m_ovf, m_tmo;

  task automatic model_clear();
    q.delete();
    nxt = 0; m_slot = 0; m_drops = 0; edge_no = 0; deadline = 0;
    busy = 0; m_start = 0; m_ovf = 0; m_tmo = 0;
  endtask

  task automatic model_drop();
    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    m_ovf = 1;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset || flush) begin
      model_clear();
    end else begin
      bit was_full, can_pop;
      was_full = (q.size() == DEPTH);
      can_pop  = rd_done && (q.size() != 0);
      edge_no++;
      m_start = 0;
      if (busy) begin
        if (frame_valid) model_drop();
        if (write_done) begin
          q.push_back(m_slot);
          nxt  = (nxt + 1) % DEPTH;
          busy = 0;
        end else if (edge_no == deadline) begin
          m_tmo = 1;
          busy  = 0;
        end
      end else if (frame_valid) begin
        if (was_full) model_drop();
        else begin
          m_start  = 1;
          m_slot   = nxt;
          busy     = 1;
          deadline = edge_no + TMO + 1;
        end
      end
      if (can_pop) void'(q.pop_front());
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("write_start", int'(write_start), int'(m_start));
      chk("write_slot", int'(write_slot), m_slot);
      chk("rd_valid", int'(rd_valid), (q.size() != 0) ? 1 : 0);
      chk("rd_slot", int'(rd_slot), (q.size() != 0) ? q[0] : nxt);
      chk("count", int'(count), q.size());
      chk("full", int'(full), (q.size() == DEPTH) ? 1 : 0);
      chk("drop_count", int'(drop_count), m_drops);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("write_timeout", int'(write_timeout), int'(m_tmo));
    end
  end

  task automatic cyc(input bit fv, input bit wd, input bit rd, input bit fl);
    frame_valid = fv; write_done = wd; rd_done = rd; flush = fl;
    @(posedge clock);
    #1;
    frame_valid = 0; write_done = 0; rd_done = 0; flush = 0;
  endtask

  task automatic write_frame();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_write_start", int'(write_start), 0);
    chk("rst_write_slot", int'(write_slot), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_write_timeout", int'(write_timeout), 0);
    reset = 1;

    // single frame, write_done six cycles after frame_valid
    cyc(1, 0, 0, 0);
    chk("single_start", int'(write_start), 1);
    chk("single_slot", int'(write_slot), 0);
    cyc(0, 0, 0, 0);
    chk("single_start_low", int'(write_start), 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("single_count", int'(count), 1);
    chk("single_rd_valid", int'(rd_valid), 1);
    chk("single_rd_slot", int'(rd_slot), 0);
    cyc(0, 0, 1, 0);
    chk("single_pop_count", int'(count), 0);

    // fill all 32 slots, then three drops
    repeat (DEPTH) write_frame();
    chk("fill_count", int'(count), 32);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("drop_no_start", int'(write_start), 0);
    end
    chk("drop_count3", int'(drop_count), 3);
    chk("drop_overflow", int'(overflow), 1);
    chk("drop_count_kept", int'(count), 32);
    cyc(0, 0, 0, 1);
    chk("flush1_drop", int'(drop_count), 0);
    chk("flush1_count", int'(count), 0);

    // wrap-around: 40 frames written then read one at a time
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, 0);
      chk("wrap_write_slot", int'(write_slot), i % 32);
      cyc(0, 1, 0, 0);
      chk("wrap_rd_slot", int'(rd_slot), i % 32);
      cyc(0, 0, 1, 0);
    end
    chk("wrap_count", int'(count), 0);
    chk("wrap_final_rd_slot", int'(rd_slot), 8);

    // simultaneous commit and pop with count=4
    repeat (4) write_frame();
    chk("sim_count_pre", int'(count), 4);
    chk("sim_rd_slot_pre", int'(rd_slot), 8);
    cyc(1, 0, 0, 0);
    chk("sim_write_slot", int'(write_slot), 12);
    cyc(0, 1, 1, 0);
    chk("sim_count", int'(count), 4);
    chk("sim_rd_slot", int'(rd_slot), 9);

    // timeout: write_done withheld
    cyc(1, 0, 0, 0);
    chk("tmo_slot", int'(write_slot), 13);
    repeat (TMO) cyc(0, 0, 0, 0);
    chk("tmo_not_yet", int'(write_timeout), 0);
    cyc(0, 0, 0, 0);
    chk("tmo_set", int'(write_timeout), 1);
    chk("tmo_count", int'(count), 4);
    cyc(0, 1, 0, 0);
    chk("tmo_late_done", int'(count), 4);
    cyc(1, 0, 0, 0);
    chk("tmo_reuse_start", int'(write_start), 1);
    chk("tmo_reuse_slot", int'(write_slot), 13);
    cyc(0, 1, 0, 0);
    chk("tmo_commit", int'(count), 5);

    // flush during an in-flight write with two drops recorded
    cyc(1, 0, 0, 0);
    chk("fl_slot", int'(write_slot), 14);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("fl_drops", int'(drop_count), 2);
    chk("fl_count_pre", int'(count), 5);
    cyc(0, 0, 0, 1);
    chk("fl_count", int'(count), 0);
    chk("fl_drop_count", int'(drop_count), 0);
    chk("fl_overflow", int'(overflow), 0);
    chk("fl_write_timeout", int'(write_timeout), 0);
    chk("fl_rd_valid", int'(rd_valid), 0);
    chk("fl_write_slot", int'(write_slot), 0);
    chk("fl_rd_slot", int'(rd_slot), 0);
    cyc(0, 1, 0, 0);
    chk("fl_late_done", int'(count), 0);
    cyc(0, 0, 1, 0);
    chk("empty_pop_count", int'(count), 0);
    chk("empty_pop_slot", int'(rd_slot), 0);
    cyc(1, 0, 0, 0);
    chk("post_flush_slot", int'(write_slot), 0);
    cyc(0, 1, 0, 0);
    chk("post_flush_count", int'(count), 1);

    // asynchronous reset mid-write
    cyc(1, 0, 0, 0);
    #2 reset = 0;
    #1;
    chk("areset_start", int'(write_start), 0);
    chk("areset_count", int'(count), 0);
    @(posedge clock);
    #1 reset = 1;
    repeat (3) cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
